image_sequencer: RTL and testbench

IMAGE_SEQUENCER -- requirements
Module: image_sequencer

---
 rtl/image_sequencer.sv | 123 ++++++++++++
 tb/tb_image_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/image_sequencer.sv
// image_sequencer: walks an image memory one index at a time, starts the
// network on each image, waits (with a watchdog) for its label and reports
// one result per image. After the last image it parks in DONE until reset.
// Optional build macro IMAGE_SEQUENCER_SCORE_EN adds expected_label and a
// correct_count score of non-timeout results that matched expectation.
module image_sequencer #(
    parameter int NUM_IMAGES     = 1,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int LW = ($clog2(NUM_CLASSES) > 0) ? $clog2(NUM_CLASSES) : 1,
    localparam int IW = ($clog2(NUM_IMAGES) > 0) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic          net_start,
    output logic [IW-1:0] image_num,
    input  logic [LW-1:0] net_label,
    input  logic          net_label_ready,
    output logic [LW-1:0] label,
    output logic [IW-1:0] label_num,
    output logic          label_ready,
    output logic          timeout,
    output logic          done
`ifdef IMAGE_SEQUENCER_SCORE_EN
    ,
    input  logic [LW-1:0] expected_label,
    output logic [IW:0]   correct_count
`endif
);

    // Watchdog counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_MAX   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IMG = IW'(NUM_IMAGES - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, RECORD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] wd_cnt;

    // Sequencer FSM; every output is a register written on the transition
    // into the state in which it must be visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            image_num   <= '0;
            label       <= '0;
            label_num   <= '0;
            net_start   <= 1'b0;
            label_ready <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
        end else begin
            net_start   <= 1'b0;
            label_ready <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                // enable is only looked at here, so a drop never aborts an
                // inference already in flight.
                IDLE: begin
                    if (enable) begin
                        state     <= START;
                        net_start <= 1'b1;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                // A real label beats a watchdog expiry in the same cycle.
                WAIT: begin
                    if (net_label_ready) begin
                        label       <= net_label;
                        label_num   <= image_num;
                        label_ready <= 1'b1;
                        state       <= RECORD;
                    end else if (wd_cnt == WD_MAX) begin
                        label       <= '1;
                        label_num   <= image_num;
                        label_ready <= 1'b1;
                        timeout     <= 1'b1;
                        state       <= RECORD;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                // Index stops at the last image instead of wrapping.
                RECORD: begin
                    if (image_num == LAST_IMG) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        image_num <= image_num + 1'b1;
                        state     <= IDLE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMAGE_SEQUENCER_SCORE_EN
    logic [LW-1:0] exp_q;

    // Expectation is latched alongside the real label; a timeout never
    // scores even if the all-ones label happens to match a stale expectation.
    always_ff @(posedge clock) begin
        if (reset) begin
            exp_q         <= '0;
            correct_count <= '0;
        end else begin
            if (state == WAIT && net_label_ready)
                exp_q <= expected_label;
            if (state == RECORD && !timeout && label == exp_q)
                correct_count <= correct_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_image_sequencer.sv
// Bench for image_sequencer: a timeline model builds the expected outputs
// for every cycle as stimulus is issued; one compare process checks them.
module tb_image_sequencer;

    localparam int N  = 4;
    localparam int NC = 10;
    localparam int T  = 8;
    localparam int LW = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          net_label_ready = 1'b1;
    logic [LW-1:0] net_label = '0;
    logic          net_start, label_ready, timeout, done;
    logic [IW-1:0] image_num, label_num;
    logic [LW-1:0] label;
`ifdef IMAGE_SEQUENCER_SCORE_EN
    logic [LW-1:0] expected_label = '0;
    logic [IW:0]   correct_count;
`endif

    always #5 clock = ~clock;

    image_sequencer #(.NUM_IMAGES(N), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .net_start(net_start), .image_num(image_num),
        .net_label(net_label), .net_label_ready(net_label_ready),
        .label(label), .label_num(label_num), .label_ready(label_ready),
        .timeout(timeout), .done(done)
`ifdef IMAGE_SEQUENCER_SCORE_EN
        , .expected_label(expected_label), .correct_count(correct_count)
`endif
    );

    typedef struct packed {
        logic          ns, lr, to, dn, chk_lbl;
        logic [IW-1:0] img, lnum;
        logic [LW-1:0] lab;
        logic [IW:0]   cc;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    int checks = 0, failures = 0;
    int cyc = 0, st_cyc = -1, lr_cyc = -1;
    logic [LW-1:0] lr_lab;
    logic          lr_to;

    // model of what has been recorded so far
    int            m_img, m_cc;
    logic [LW-1:0] m_lab;
    logic [IW-1:0] m_lnum;
    logic          m_done;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic ns, lr, to, cl);
        exp_t e;
        e.ns = ns; e.lr = lr; e.to = to; e.dn = m_done; e.chk_lbl = cl;
        e.img = IW'(m_img); e.lnum = m_lnum; e.lab = m_lab; e.cc = (IW+1)'(m_cc);
        return e;
    endfunction

    function automatic logic [LW-1:0] rl();
        return LW'($urandom);
    endfunction

    task automatic model_reset();
        m_img = 0; m_cc = 0; m_lab = '0; m_lnum = '0; m_done = 1'b0;
    endtask

    // drive inputs for the next rising edge; e is the state expected after it
    task automatic cycle(input logic rst, en, rdy, input logic [LW-1:0] nl, el, input exp_t e);
        @(negedge clock);
        reset = rst; enable = en; net_label_ready = rdy; net_label = nl;
`ifdef IMAGE_SEQUENCER_SCORE_EN
        expected_label = el;
`endif
        exp_q.push_back(e);
    endtask

    // compare DUT against the model every cycle after the edge
    always @(posedge clock) begin
        #1;
        cyc++;
        if (net_start) st_cyc = cyc;
        if (label_ready) begin lr_cyc = cyc; lr_lab = label; lr_to = timeout; end
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("net_start", net_start, ce.ns);
            chk("label_ready", label_ready, ce.lr);
            chk("timeout", timeout, ce.to);
            chk("done", done, ce.dn);
            chk("image_num", image_num, ce.img);
            if (ce.lr || ce.chk_lbl) begin
                chk("label", label, ce.lab);
                chk("label_num", label_num, ce.lnum);
            end
`ifdef IMAGE_SEQUENCER_SCORE_EN
            chk("correct_count", correct_count, ce.cc);
`endif
        end
    end

    // One image: idle_low IDLE cycles with enable low, then start; the
    // network answers in WAIT cycle resp (resp >= T means never).
    task automatic run_image(input int idle_low, input int resp,
                             input logic [LW-1:0] lbl, input logic [LW-1:0] el);
        logic to;
        to = 1'b0;
        for (int i = 0; i < idle_low; i++)
            cycle(0, 0, 1'($urandom), rl(), rl(), mk(0, 0, 0, 0));
        cycle(0, 1, 1'($urandom), rl(), rl(), mk(1, 0, 0, 0));
        cycle(0, 1'($urandom), 1'($urandom), rl(), rl(), mk(0, 0, 0, 0));
        for (int n = 0; n < T; n++) begin
            if (n == resp) begin
                m_lab = lbl; m_lnum = IW'(m_img);
                cycle(0, 1'($urandom), 1, lbl, el, mk(0, 1, 0, 0));
                break;
            end
            if (n == T - 1) begin
                m_lab = '1; m_lnum = IW'(m_img); to = 1'b1;
                cycle(0, 1'($urandom), 0, rl(), rl(), mk(0, 1, 1, 0));
                break;
            end
            cycle(0, 1'($urandom), 0, rl(), rl(), mk(0, 0, 0, 0));
        end
        if (!to && lbl == el) m_cc++;
        if (m_img == N - 1) m_done = 1'b1;
        else m_img++;
        cycle(0, 1'($urandom), 1'($urandom), rl(), rl(), mk(0, 0, 0, 0));
    endtask

    int st_a[N], lr_a[N];
    logic [LW-1:0] lab_a[N];
    logic to_a[N];
    int idl[N] = '{0, 0, 0, 3};
    int rsp[N] = '{2, 7, 99, 0};
    logic [LW-1:0] lbs[N] = '{4'd7, 4'd5, 4'd2, 4'd9};
    logic [LW-1:0] els[N] = '{4'd7, 4'd15, 4'd0, 4'd9};

    initial begin
        model_reset();
        // reset overrides enable and label_ready
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, rl(), rl(), mk(0, 0, 0, 1));

        // directed run: normal, tie at watchdog limit, timeout, paused start
        for (int i = 0; i < N; i++) begin
            run_image(idl[i], rsp[i], lbs[i], els[i]);
            st_a[i] = st_cyc; lr_a[i] = lr_cyc; lab_a[i] = lr_lab; to_a[i] = lr_to;
        end
        for (int i = 0; i < 8; i++)
            cycle(0, 1'($urandom), 1'($urandom), rl(), rl(), mk(0, 0, 0, 0));

        chk("lat_label3", lr_a[0] - st_a[0], 4);
        chk("label_7", lab_a[0], 7);
        chk("gap_start", st_a[1] - lr_a[0], 2);
        chk("lat_tie", lr_a[1] - st_a[1], 9);
        chk("tie_no_timeout", to_a[1], 0);
        chk("lat_timeout", lr_a[2] - st_a[2], 9);
        chk("timeout_flag", to_a[2], 1);
        chk("timeout_label", lab_a[2], 15);
        chk("gap_paused", st_a[3] - lr_a[2], 5);
        chk("lat_immediate", lr_a[3] - st_a[3], 2);
        chk("done_level", done, 1);
        chk("last_index", image_num, N - 1);
`ifdef IMAGE_SEQUENCER_SCORE_EN
        chk("score_at_done", correct_count, 2);
`endif

        // reset in the middle of WAIT with a coincident label, then a stray
        // label in IDLE that must be ignored
        model_reset();
        cycle(1, 0, 0, rl(), rl(), mk(0, 0, 0, 1));
        cycle(0, 1, 0, rl(), rl(), mk(1, 0, 0, 1));
        cycle(0, 1, 0, rl(), rl(), mk(0, 0, 0, 1));
        cycle(0, 1, 0, rl(), rl(), mk(0, 0, 0, 1));
        cycle(1, 1, 1, 4'd7, 4'd7, mk(0, 0, 0, 1));
        cycle(0, 0, 1, 4'd9, 4'd9, mk(0, 0, 0, 1));
        cycle(0, 0, 0, rl(), rl(), mk(0, 0, 0, 1));

        // randomized runs, each ending in DONE and a reset
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                logic [LW-1:0] lb, ex;
                lb = LW'($urandom_range(0, NC - 1));
                ex = ($urandom_range(0, 1) == 1) ? lb : rl();
                run_image($urandom_range(0, 3), $urandom_range(0, T + 1), lb, ex);
            end
            for (int i = 0; i < 3; i++)
                cycle(0, 1'($urandom), 1'($urandom), rl(), rl(), mk(0, 0, 0, 0));
            model_reset();
            cycle(1, 1'($urandom), 1'($urandom), rl(), rl(), mk(0, 0, 0, 1));
        end

        cycle(0, 0, 0, rl(), rl(), mk(0, 0, 0, 1));
        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
